// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: collects one-cycle pulses from N button channels, latches
// them as pending presses and serialises them round-robin onto a single
// valid/ready event stream. A press arriving on a channel that is already
// pending (and not being accepted) is dropped and flags a sticky overflow.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pulse_in  in   [N-1:0] one-cycle pulses, bit i = channel i
//   evt_ready in   consumer accepts the offered event this cycle
//   clr_ovf   in   clears the overflow flag (a new drop in the same cycle wins)
//   evt_valid out  event offered on evt_id
//   evt_id    out  [IDW-1:0] channel number of the offered event
//   pending   out  [N-1:0] per-channel pending-press latch
//   overflow  out  sticky lost-press flag
module btn_event_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   pulse_in,
  input  logic           evt_ready,
  input  logic           clr_ovf,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   pending,
  output logic           overflow
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  state_e         state_q,     state_d;
  logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
  logic           evt_valid_q, evt_valid_d;
  logic [IDW-1:0] evt_id_q,    evt_id_d;
  logic [N-1:0]   pending_q,   pending_d;
  logic           overflow_q,  overflow_d;

  logic           accept;
  logic [N-1:0]   acc_vec;
  logic           drop;
  logic           found;
  logic [IDW-1:0] pick;
  int unsigned    idx;

  // Accept handshake and one-hot of the channel being accepted this cycle
  always_comb begin
    accept  = (state_q == S_OFFER) && evt_ready;
    acc_vec = '0;
    if (accept) begin
      acc_vec = N'(1) << evt_id_q;
    end
  end

  // Pending latches: accept clears, a simultaneous new pulse re-sets (new press)
  always_comb begin
    pending_d  = (pending_q & ~acc_vec) | pulse_in;
    drop       = |(pulse_in & pending_q & ~acc_vec);
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Round-robin pick: first pending bit scanning rr_ptr, rr_ptr+1, ... wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    unique case (state_q)
      S_IDLE: begin
        evt_valid_d = 1'b0;
        if (found) begin
          evt_id_d    = pick;
          evt_valid_d = 1'b1;
          state_d     = S_OFFER;
        end
      end
      S_OFFER: begin
        // id is frozen until accepted, regardless of new higher-priority presses
        if (accept) begin
          rr_ptr_d    = (evt_id_q == IDW'(N - 1)) ? '0 : evt_id_q + IDW'(1);
          evt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed testbench for btn_event_arbiter (N=4). Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point.
module tb_btn_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] pulse_in;
  logic       evt_ready;
  logic       clr_ovf;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic       overflow;

  int vec_cnt;
  int err_cnt;

  btn_event_arbiter #(.N(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    pulse_in  = '0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse_in  = 4'(i + 1) | 4'b1000;
      evt_ready = i[0];
      clr_ovf   = ~i[0];
      tick();
    end
    vec_cnt++;
    if (evt_valid !== 1'b0) begin
      err_cnt++; $display("FAIL reset_valid: got %b want 0", evt_valid);
    end
    vec_cnt++;
    if (evt_id !== 2'd0) begin
      err_cnt++; $display("FAIL reset_id: got %0d want 0", evt_id);
    end
    vec_cnt++;
    if (pending !== 4'b0000) begin
      err_cnt++; $display("FAIL reset_pending: got %b want 0000", pending);
    end
    vec_cnt++;
    if (overflow !== 1'b0) begin
      err_cnt++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    apply_reset();
  endtask

  task automatic test_single_press();
    apply_reset();
    evt_ready = 1'b1;
    pulse_in  = 4'b0100;
    tick();
    pulse_in = '0;
    vec_cnt++;
    if (pending !== 4'b0100 || evt_valid !== 1'b0) begin
      err_cnt++; $display("FAIL single_c1: pending=%b valid=%b want 0100/0", pending, evt_valid);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      err_cnt++; $display("FAIL single_c2: valid=%b id=%0d want 1/2", evt_valid, evt_id);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
      err_cnt++; $display("FAIL single_c3: valid=%b pending=%b want 0/0000", evt_valid, pending);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a [3];
    logic [1:0] exp_b [2];
    logic [1:0] exp_c [2];
    exp_a = '{2'd0, 2'd1, 2'd3};
    exp_b = '{2'd0, 2'd1};
    exp_c = '{2'd3, 2'd0};
    apply_reset();
    evt_ready = 1'b1;

    pulse_in = 4'b1011;
    tick();
    pulse_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (evt_valid !== 1'b1 || evt_id !== exp_a[i]) begin
        err_cnt++; $display("FAIL rr_a%0d: valid=%b id=%0d want 1/%0d", i, evt_valid, evt_id, exp_a[i]);
      end
      tick();
      vec_cnt++;
      if (evt_valid !== 1'b0) begin
        err_cnt++; $display("FAIL rr_a%0d_bubble: valid=%b want 0", i, evt_valid);
      end
    end

    pulse_in = 4'b0011;
    tick();
    pulse_in = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++;
      if (evt_valid !== 1'b1 || evt_id !== exp_b[i]) begin
        err_cnt++; $display("FAIL rr_b%0d: valid=%b id=%0d want 1/%0d", i, evt_valid, evt_id, exp_b[i]);
      end
      tick();
    end

    pulse_in = 4'b1001;
    tick();
    pulse_in = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++;
      if (evt_valid !== 1'b1 || evt_id !== exp_c[i]) begin
        err_cnt++; $display("FAIL rr_c%0d: valid=%b id=%0d want 1/%0d", i, evt_valid, evt_id, exp_c[i]);
      end
      tick();
    end
    vec_cnt++;
    if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
      err_cnt++; $display("FAIL rr_end: pending=%b valid=%b want 0000/0", pending, evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    evt_ready = 1'b0;
    pulse_in  = 4'b0100;
    tick();
    pulse_in = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      // channel 0 would win the scan from rr_ptr=0, but the offer is frozen
      pulse_in = (i == 0) ? 4'b0001 : 4'b0000;
      tick();
      pulse_in = '0;
      vec_cnt++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
        err_cnt++; $display("FAIL bp_hold%0d: valid=%b id=%0d want 1/2", i, evt_valid, evt_id);
      end
    end
    vec_cnt++;
    if (overflow !== 1'b0 || pending !== 4'b0101) begin
      err_cnt++; $display("FAIL bp_no_ovf: overflow=%b pending=%b want 0/0101", overflow, pending);
    end

    pulse_in = 4'b0100;
    tick();
    pulse_in = '0;
    vec_cnt++;
    if (overflow !== 1'b1) begin
      err_cnt++; $display("FAIL bp_ovf_set: got %b want 1", overflow);
    end

    pulse_in = 4'b0100;
    clr_ovf  = 1'b1;
    tick();
    pulse_in = '0;
    vec_cnt++;
    if (overflow !== 1'b1) begin
      err_cnt++; $display("FAIL bp_set_wins: got %b want 1", overflow);
    end

    tick();
    clr_ovf = 1'b0;
    vec_cnt++;
    if (overflow !== 1'b0) begin
      err_cnt++; $display("FAIL bp_clr: got %b want 0", overflow);
    end

    evt_ready = 1'b1;
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || pending !== 4'b0001) begin
      err_cnt++; $display("FAIL bp_accept: valid=%b pending=%b want 0/0001", evt_valid, pending);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      err_cnt++; $display("FAIL bp_next: valid=%b id=%0d want 1/0", evt_valid, evt_id);
    end
    tick();
    vec_cnt++;
    if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
      err_cnt++; $display("FAIL bp_drain: pending=%b valid=%b want 0000/0", pending, evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_repress_on_accept();
    apply_reset();
    evt_ready = 1'b0;
    pulse_in  = 4'b0010;
    tick();
    pulse_in = '0;
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      err_cnt++; $display("FAIL rep_offer: valid=%b id=%0d want 1/1", evt_valid, evt_id);
    end
    evt_ready = 1'b1;
    pulse_in  = 4'b0010;
    tick();
    pulse_in = '0;
    vec_cnt++;
    if (evt_valid !== 1'b0 || pending !== 4'b0010 || overflow !== 1'b0) begin
      err_cnt++; $display("FAIL rep_keep: valid=%b pending=%b ovf=%b want 0/0010/0", evt_valid, pending, overflow);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      err_cnt++; $display("FAIL rep_reoffer: valid=%b id=%0d want 1/1", evt_valid, evt_id);
    end
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000 || overflow !== 1'b0) begin
      err_cnt++; $display("FAIL rep_done: valid=%b pending=%b ovf=%b want 0/0000/0", evt_valid, pending, overflow);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_offer();
    apply_reset();
    evt_ready = 1'b0;
    pulse_in  = 4'b1000;
    tick();
    pulse_in = 4'b0001;
    tick();
    pulse_in = '0;
    vec_cnt++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      err_cnt++; $display("FAIL mid_offer: valid=%b id=%0d want 1/3", evt_valid, evt_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000 || evt_id !== 2'd0 || overflow !== 1'b0) begin
      err_cnt++; $display("FAIL mid_async: valid=%b pending=%b id=%0d ovf=%b want 0/0000/0/0",
                          evt_valid, pending, evt_id, overflow);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
        err_cnt++; $display("FAIL mid_idle%0d: valid=%b pending=%b want 0/0000", i, evt_valid, pending);
      end
    end
    pulse_in = 4'b0100;
    tick();
    pulse_in = '0;
    tick();
    vec_cnt++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      err_cnt++; $display("FAIL mid_after: valid=%b id=%0d want 1/2", evt_valid, evt_id);
    end
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    pulse_in  = '0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    #1;
    test_reset();
    test_single_press();
    test_round_robin();
    test_backpressure();
    test_repress_on_accept();
    test_reset_mid_offer();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
